cajero_param: RTL and testbench
===============================

// Module: cajero_param
// PURPOSE
//   Parametrised next-generation ATM session controller replacing the fixed 4-digit, single-transaction Cajero.
//   Handles card insertion, N-digit PIN entry with attempt limiting, and multiple deposits/withdrawals per session.
//   Adds a per-session cumulative withdrawal limit and an inactivity timeout.
//   Sits between keypad/card-reader front end and the cash dispenser/account back end.
// PARAMETERS
//   N_DIGITS      4       PIN length in BCD digits
//   BAL_W         64      balance width (bits)
//   MONTO_W       32      transaction amount width (bits), MONTO_W <= BAL_W
//   MAX_INTENTOS  3       wrong PINs before permanent block (>=2)
//   LIMITE_RETIRO 100000  max cumulative withdrawal per session
//   TIMEOUT_CYC   1024    idle cycles in LEER_PIN/TRANS before session abort
// PORTS
//   CLK                  in   1           clock, rising edge
//   RESET                in   1           asynchronous, active-high
//   TARJETA_RECIBIDA     in   1           card inserted (sampled in IDLE only)
//   PIN_CORRECTO         in   4*N_DIGITS  expected PIN, BCD, most significant digit in top nibble
//   DIGITO               in   4           keypad digit
//   DIGITO_STB           in   1           DIGITO valid, 1-cycle strobe
//   TIPO_TRANS           in   1           0 = deposit, 1 = withdrawal; sampled with MONTO_STB
//   MONTO                in   MONTO_W     amount
//   MONTO_STB            in   1           MONTO/TIPO_TRANS valid, 1-cycle strobe
//   FIN_SESION           in   1           user ends session
//   BALANCE_INICIAL      in   BAL_W       balance loaded at card insertion
//   BALANCE_ACTUALIZADO  out  BAL_W       current session balance (registered)
//   BALANCE_STB          out  1           1-cycle pulse, balance changed
//   ENTREGAR_DINERO      out  1           1-cycle pulse, dispense cash
//   FONDOS_INSUFICIENTES out  1           1-cycle pulse, withdrawal > balance
//   LIMITE_EXCEDIDO      out  1           1-cycle pulse, session limit would be exceeded
//   PIN_INCORRECTO       out  1           1-cycle pulse per wrong PIN
//   ADVERTENCIA          out  1           level: one attempt left
//   BLOQUEO              out  1           level: card blocked, sticky until RESET
//   TIMEOUT              out  1           1-cycle pulse, session aborted by inactivity
// BEHAVIOUR
//   - Reset: state IDLE; all outputs, balance, attempt count, withdrawal sum, timers = 0.
//   - States: IDLE, LEER_PIN, VERIFICAR, TRANS, BLOQUEADO.
//   - IDLE: TARJETA_RECIBIDA=1 -> load balance from BALANCE_INICIAL; clear digit count and withdrawal sum; go to LEER_PIN.
//     TARJETA_RECIBIDA is ignored in all other states.
//   - LEER_PIN: each DIGITO_STB with DIGITO<=9 shifts the digit in from the LSB and increments the count.
//     DIGITO>9 is ignored. After the N_DIGITS-th digit, go to VERIFICAR.
//   - VERIFICAR (1 cycle), match: clear attempt count and ADVERTENCIA; go to TRANS.
//   - VERIFICAR, mismatch: increment attempt count; pulse PIN_INCORRECTO; clear digit count.
//     New count == MAX_INTENTOS-1 -> ADVERTENCIA=1; go to LEER_PIN.
//     New count == MAX_INTENTOS -> BLOQUEO=1; go to BLOQUEADO.
//   - TRANS, MONTO_STB: result registered the next cycle. MONTO=0 is ignored.
//     Deposit: balance += zero-extended MONTO, saturating at 2^BAL_W-1; BALANCE_STB.
//     Withdrawal, MONTO > balance: pulse FONDOS_INSUFICIENTES only (checked first).
//     Withdrawal, sum+MONTO > LIMITE_RETIRO: pulse LIMITE_EXCEDIDO only.
//     Withdrawal, otherwise: balance -= MONTO; sum += MONTO; pulse ENTREGAR_DINERO and BALANCE_STB together.
//   - TRANS accepts unlimited transactions. FIN_SESION -> IDLE.
//     MONTO_STB and FIN_SESION in the same cycle: the transaction completes, then IDLE.
//   - DIGITO_STB is ignored outside LEER_PIN; MONTO_STB is ignored outside TRANS.
//   - Timeout counter: cleared on any accepted strobe and on state entry. Counts only in LEER_PIN and TRANS.
//     Reaching TIMEOUT_CYC -> pulse TIMEOUT; go to IDLE. Attempt count persists across timeouts; only RESET clears it.
//   - ADVERTENCIA clears on a correct PIN. It is not cleared on FIN_SESION or timeout.
//   - BLOQUEADO: all inputs ignored; only RESET exits.
//   - RESET mid-transaction aborts with no pulses; balance returns to 0.
// STRUCTURE
//   - cajero_pkg: state encoding localparams, TIPO_DEPOSITO/TIPO_RETIRO constants.
//   - Sub-module cajero_pin_capture: digit shift register, digit counter, done flag, equality compare.
//     Parametrised by N_DIGITS.
//   - Top level: FSM, balance/sum arithmetic, timeout counter, output registers.
// TESTING
//   1. PIN 1234, balance 500; enter 1,2,3,4; withdraw 200 -> ENTREGAR_DINERO + BALANCE_STB, BALANCE_ACTUALIZADO=300.
//   2. Wrong PIN 1111 x2 -> PIN_INCORRECTO x2, ADVERTENCIA after 2nd; 3rd wrong -> BLOQUEO=1; later card/digits ignored.
//   3. Balance 50, withdraw 80 -> FONDOS_INSUFICIENTES only, balance stays 50; then deposit 30 -> BALANCE_ACTUALIZADO=80.
//   4. Balance 300000, withdraw 60000 twice -> 2nd gives LIMITE_EXCEDIDO, balance 240000; withdraw 40000 -> accepted.
//   5. TIMEOUT_CYC=16; insert card, no digits 16 cycles -> TIMEOUT pulse, IDLE; MONTO_STB+FIN_SESION same cycle -> applied then IDLE.
//   6. Deposit near 2^BAL_W-1 saturates; DIGITO=0xA ignored; RESET in TRANS -> all outputs 0.

Source files
------------

// File: rtl/cajero_pkg.sv
// Shared definitions for the parametrised ATM session controller.
// State encoding and transaction type constants.
package cajero_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LEER_PIN  = 3'd1;
    localparam logic [2:0] ST_VERIFICAR = 3'd2;
    localparam logic [2:0] ST_TRANS     = 3'd3;
    localparam logic [2:0] ST_BLOQUEADO = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        LEER_PIN  = ST_LEER_PIN,
        VERIFICAR = ST_VERIFICAR,
        TRANS     = ST_TRANS,
        BLOQUEADO = ST_BLOQUEADO
    } estado_t;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_pin_capture.sv
// PIN digit capture: BCD shift register, digit counter,
// last-digit flag and comparison against the expected PIN.
module cajero_pin_capture #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  stb,
    input  logic [3:0]            digito,
    input  logic [4*N_DIGITS-1:0] pin_correcto,
    output logic                  acepta,
    output logic                  done,
    output logic                  match
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int SR_W  = 4 * N_DIGITS;

    logic [SR_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W+3:0]  shreg_ext;

    assign shreg_ext = {shreg_q, digito};
    assign acepta    = stb && (digito <= 4'd9);
    assign match     = (shreg_q == pin_correcto);

    // Shift accepted digits in at the LSB and count them
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (acepta) begin
            shreg_d = shreg_ext[SR_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            done    = (cnt_q == CNT_W'(N_DIGITS - 1));
        end
    end

    // Capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cajero_param.sv
// ATM session controller: card, PIN with attempt limit,
// multi-transaction sessions, withdrawal cap and idle timeout.
module cajero_param
    import cajero_pkg::*;
#(
    parameter int              N_DIGITS      = 4,
    parameter int              BAL_W         = 64,
    parameter int              MONTO_W       = 32,
    parameter int              MAX_INTENTOS  = 3,
    parameter longint unsigned LIMITE_RETIRO = 100000,
    parameter int              TIMEOUT_CYC   = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  TARJETA_RECIBIDA,
    input  logic [4*N_DIGITS-1:0] PIN_CORRECTO,
    input  logic [3:0]            DIGITO,
    input  logic                  DIGITO_STB,
    input  logic                  TIPO_TRANS,
    input  logic [MONTO_W-1:0]    MONTO,
    input  logic                  MONTO_STB,
    input  logic                  FIN_SESION,
    input  logic [BAL_W-1:0]      BALANCE_INICIAL,
    output logic [BAL_W-1:0]      BALANCE_ACTUALIZADO,
    output logic                  BALANCE_STB,
    output logic                  ENTREGAR_DINERO,
    output logic                  FONDOS_INSUFICIENTES,
    output logic                  LIMITE_EXCEDIDO,
    output logic                  PIN_INCORRECTO,
    output logic                  ADVERTENCIA,
    output logic                  BLOQUEO,
    output logic                  TIMEOUT
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0]  INT_MAX  = IW'(MAX_INTENTOS);
    localparam logic [IW-1:0]  INT_ADV  = IW'(MAX_INTENTOS - 1);
    localparam logic [BAL_W:0] LIM      = (BAL_W + 1)'(LIMITE_RETIRO);

    estado_t          estado_q, estado_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [BAL_W-1:0] suma_q, suma_d;
    logic [IW-1:0]    intentos_q, intentos_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             adv_q, adv_d;
    logic             bloq_q, bloq_d;
    logic             bal_stb_q, bal_stb_d;
    logic             entregar_q, entregar_d;
    logic             fondos_q, fondos_d;
    logic             limite_q, limite_d;
    logic             pin_inc_q, pin_inc_d;
    logic             timeout_q, timeout_d;

    logic             dig_ok, dig_done, pin_match;
    logic             strobe_ok;
    logic [IW-1:0]    intentos_inc;
    logic [BAL_W-1:0] monto_ext;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W-1:0] dep_sat;
    logic [BAL_W:0]   suma_nueva;

    cajero_pin_capture #(
        .N_DIGITS (N_DIGITS)
    ) u_pin (
        .clk          (CLK),
        .rst          (RESET),
        .clr          (estado_q != LEER_PIN),
        .stb          (DIGITO_STB && (estado_q == LEER_PIN)),
        .digito       (DIGITO),
        .pin_correcto (PIN_CORRECTO),
        .acepta       (dig_ok),
        .done         (dig_done),
        .match        (pin_match)
    );

    assign intentos_inc = intentos_q + IW'(1);
    assign monto_ext    = BAL_W'(MONTO);
    assign dep_sum      = {1'b0, bal_q} + {1'b0, monto_ext};
    assign dep_sat      = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
    assign suma_nueva   = {1'b0, suma_q} + {1'b0, monto_ext};

    // Next-state, arithmetic and output pulse decisions
    always_comb begin
        estado_d   = estado_q;
        bal_d      = bal_q;
        suma_d     = suma_q;
        intentos_d = intentos_q;
        tmr_d      = '0;
        adv_d      = adv_q;
        bloq_d     = bloq_q;
        bal_stb_d  = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;
        limite_d   = 1'b0;
        pin_inc_d  = 1'b0;
        timeout_d  = 1'b0;
        strobe_ok  = 1'b0;
        unique case (estado_q)
            IDLE: begin
                if (TARJETA_RECIBIDA) begin
                    bal_d    = BALANCE_INICIAL;
                    suma_d   = '0;
                    estado_d = LEER_PIN;
                end
            end
            LEER_PIN: begin
                strobe_ok = dig_ok;
                if (dig_done) begin
                    estado_d = VERIFICAR;
                end else if (!dig_ok && tmr_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    estado_d  = IDLE;
                end
            end
            VERIFICAR: begin
                if (pin_match) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                    estado_d   = TRANS;
                end else begin
                    intentos_d = intentos_inc;
                    pin_inc_d  = 1'b1;
                    if (intentos_inc == INT_MAX) begin
                        bloq_d   = 1'b1;
                        estado_d = BLOQUEADO;
                    end else begin
                        if (intentos_inc == INT_ADV) begin
                            adv_d = 1'b1;
                        end
                        estado_d = LEER_PIN;
                    end
                end
            end
            TRANS: begin
                if (MONTO_STB && MONTO != '0) begin
                    strobe_ok = 1'b1;
                    if (TIPO_TRANS == TIPO_DEPOSITO) begin
                        bal_d     = dep_sat;
                        bal_stb_d = 1'b1;
                    end else if (TIPO_TRANS == TIPO_RETIRO) begin
                        if (monto_ext > bal_q) begin
                            fondos_d = 1'b1;
                        end else if (suma_nueva > LIM) begin
                            limite_d = 1'b1;
                        end else begin
                            bal_d      = bal_q - monto_ext;
                            suma_d     = suma_nueva[BAL_W-1:0];
                            entregar_d = 1'b1;
                            bal_stb_d  = 1'b1;
                        end
                    end
                end
                if (FIN_SESION) begin
                    estado_d = IDLE;
                end else if (!strobe_ok && tmr_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    estado_d  = IDLE;
                end
            end
            BLOQUEADO: begin
                estado_d = BLOQUEADO;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
        // Idle timer runs only while waiting for the user
        if ((estado_q == LEER_PIN || estado_q == TRANS) &&
            estado_d == estado_q && !strobe_ok) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Single register bank for FSM, datapath and outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado_q   <= IDLE;
            bal_q      <= '0;
            suma_q     <= '0;
            intentos_q <= '0;
            tmr_q      <= '0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            bal_stb_q  <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
            limite_q   <= 1'b0;
            pin_inc_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            bal_q      <= bal_d;
            suma_q     <= suma_d;
            intentos_q <= intentos_d;
            tmr_q      <= tmr_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            bal_stb_q  <= bal_stb_d;
            entregar_q <= entregar_d;
            fondos_q   <= fondos_d;
            limite_q   <= limite_d;
            pin_inc_q  <= pin_inc_d;
            timeout_q  <= timeout_d;
        end
    end

    assign BALANCE_ACTUALIZADO  = bal_q;
    assign BALANCE_STB          = bal_stb_q;
    assign ENTREGAR_DINERO      = entregar_q;
    assign FONDOS_INSUFICIENTES = fondos_q;
    assign LIMITE_EXCEDIDO      = limite_q;
    assign PIN_INCORRECTO       = pin_inc_q;
    assign ADVERTENCIA          = adv_q;
    assign BLOQUEO              = bloq_q;
    assign TIMEOUT              = timeout_q;

endmodule

// File: tb/tb_cajero_param.sv
// Directed bench for cajero_param.
// Output vector: {BAL_STB,ENTREGAR,FONDOS,LIMITE,PIN_INC,ADV,BLOQ,TIMEOUT}.
module tb_cajero_param;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        TARJETA_RECIBIDA;
    logic [15:0] PIN_CORRECTO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        FIN_SESION;
    logic [63:0] BALANCE_INICIAL;
    logic [63:0] BALANCE_ACTUALIZADO;
    logic        BALANCE_STB;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        LIMITE_EXCEDIDO;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;
    logic        TIMEOUT;

    int n_chk = 0;
    int n_err = 0;

    cajero_param #(
        .N_DIGITS      (4),
        .BAL_W         (64),
        .MONTO_W       (32),
        .MAX_INTENTOS  (3),
        .LIMITE_RETIRO (100000),
        .TIMEOUT_CYC   (16)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .PIN_CORRECTO         (PIN_CORRECTO),
        .DIGITO               (DIGITO),
        .DIGITO_STB           (DIGITO_STB),
        .TIPO_TRANS           (TIPO_TRANS),
        .MONTO                (MONTO),
        .MONTO_STB            (MONTO_STB),
        .FIN_SESION           (FIN_SESION),
        .BALANCE_INICIAL      (BALANCE_INICIAL),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .BALANCE_STB          (BALANCE_STB),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .LIMITE_EXCEDIDO      (LIMITE_EXCEDIDO),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO),
        .TIMEOUT              (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {BALANCE_STB, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
                LIMITE_EXCEDIDO, PIN_INCORRECTO, ADVERTENCIA,
                BLOQUEO, TIMEOUT};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic insert(input logic [63:0] bal);
        BALANCE_INICIAL  = bal;
        TARJETA_RECIBIDA = 1'b1;
        tick();
        TARJETA_RECIBIDA = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        DIGITO     = d;
        DIGITO_STB = 1'b1;
        tick();
        DIGITO_STB = 1'b0;
    endtask

    // Four digits, then the verify cycle
    task automatic enter_pin(input logic [15:0] p);
        digit(p[15:12]);
        digit(p[11:8]);
        digit(p[7:4]);
        digit(p[3:0]);
        tick();
    endtask

    task automatic trans(input logic tipo, input logic [31:0] m);
        TIPO_TRANS = tipo;
        MONTO      = m;
        MONTO_STB  = 1'b1;
        tick();
        MONTO_STB  = 1'b0;
    endtask

    task automatic fin();
        FIN_SESION = 1'b1;
        tick();
        FIN_SESION = 1'b0;
    endtask

    initial begin
        RESET            = 1'b1;
        TARJETA_RECIBIDA = 1'b0;
        PIN_CORRECTO     = 16'h1234;
        DIGITO           = 4'd0;
        DIGITO_STB       = 1'b0;
        TIPO_TRANS       = 1'b0;
        MONTO            = '0;
        MONTO_STB        = 1'b0;
        FIN_SESION       = 1'b0;
        BALANCE_INICIAL  = '0;
        tick();
        tick();
        chk("reset_outs", 64'(outs()), 64'h00);
        chk("reset_bal", BALANCE_ACTUALIZADO, 64'd0);
        RESET = 1'b0;
        tick();

        // Correct PIN, withdrawal of 200 from 500
        insert(64'd500);
        chk("t1_load", BALANCE_ACTUALIZADO, 64'd500);
        enter_pin(16'h1234);
        chk("t1_verify", 64'(outs()), 64'h00);
        trans(1'b1, 32'd200);
        chk("t1_wd_outs", 64'(outs()), 64'hC0);
        chk("t1_wd_bal", BALANCE_ACTUALIZADO, 64'd300);
        tick();
        chk("t1_pulse_end", 64'(outs()), 64'h00);
        fin();

        // Insufficient funds, then deposit
        insert(64'd50);
        enter_pin(16'h1234);
        trans(1'b1, 32'd80);
        chk("t3_nsf_outs", 64'(outs()), 64'h20);
        chk("t3_nsf_bal", BALANCE_ACTUALIZADO, 64'd50);
        trans(1'b0, 32'd30);
        chk("t3_dep_outs", 64'(outs()), 64'h80);
        chk("t3_dep_bal", BALANCE_ACTUALIZADO, 64'd80);
        fin();

        // Session withdrawal limit of 100000
        insert(64'd300000);
        enter_pin(16'h1234);
        trans(1'b1, 32'd60000);
        chk("t4_wd1_outs", 64'(outs()), 64'hC0);
        chk("t4_wd1_bal", BALANCE_ACTUALIZADO, 64'd240000);
        trans(1'b1, 32'd60000);
        chk("t4_lim_outs", 64'(outs()), 64'h10);
        chk("t4_lim_bal", BALANCE_ACTUALIZADO, 64'd240000);
        trans(1'b1, 32'd40000);
        chk("t4_wd3_outs", 64'(outs()), 64'hC0);
        chk("t4_wd3_bal", BALANCE_ACTUALIZADO, 64'd200000);
        trans(1'b1, 32'd0);
        chk("t4_zero_outs", 64'(outs()), 64'h00);
        fin();

        // Invalid digit ignored, saturating deposit, reset in TRANS
        insert(64'hFFFF_FFFF_FFFF_FFF6);
        digit(4'd1);
        digit(4'hA);
        digit(4'd2);
        digit(4'd3);
        digit(4'd4);
        tick();
        chk("t6_digit_a", 64'(outs()), 64'h00);
        trans(1'b0, 32'd100);
        chk("t6_sat_outs", 64'(outs()), 64'h80);
        chk("t6_sat_bal", BALANCE_ACTUALIZADO, 64'hFFFF_FFFF_FFFF_FFFF);
        TIPO_TRANS = 1'b1;
        MONTO      = 32'd5;
        MONTO_STB  = 1'b1;
        RESET      = 1'b1;
        #1;
        chk("t6_rst_async", BALANCE_ACTUALIZADO, 64'd0);
        tick();
        chk("t6_rst_outs", 64'(outs()), 64'h00);
        chk("t6_rst_bal", BALANCE_ACTUALIZADO, 64'd0);
        MONTO_STB = 1'b0;
        RESET     = 1'b0;
        tick();

        // Idle timeout after 16 cycles in LEER_PIN
        insert(64'd100);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_pre_to", 64'(outs()), 64'h00);
        tick();
        chk("t5_timeout", 64'(outs()), 64'h01);
        insert(64'd700);
        chk("t5_idle_after_to", BALANCE_ACTUALIZADO, 64'd700);
        enter_pin(16'h1234);
        TIPO_TRANS = 1'b0;
        MONTO      = 32'd20;
        MONTO_STB  = 1'b1;
        FIN_SESION = 1'b1;
        tick();
        MONTO_STB  = 1'b0;
        FIN_SESION = 1'b0;
        chk("t5_fin_outs", 64'(outs()), 64'h80);
        chk("t5_fin_bal", BALANCE_ACTUALIZADO, 64'd720);
        insert(64'd10);
        chk("t5_idle_after_fin", BALANCE_ACTUALIZADO, 64'd10);

        // Wrong PIN three times leads to a permanent block
        enter_pin(16'h1111);
        chk("t2_wrong1", 64'(outs()), 64'h08);
        enter_pin(16'h1111);
        chk("t2_wrong2", 64'(outs()), 64'h0C);
        enter_pin(16'h1111);
        chk("t2_wrong3", 64'(outs()), 64'h0E);
        tick();
        chk("t2_block_lvl", 64'(outs()), 64'h06);
        insert(64'd999);
        enter_pin(16'h1234);
        for (int i = 0; i < 20; i++) tick();
        chk("t2_block_outs", 64'(outs()), 64'h06);
        chk("t2_block_bal", BALANCE_ACTUALIZADO, 64'd10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
